// File: rtl/decode_stage.sv
// Registered RV32I decode stage (OP_IMM, LUI, AUIPC) feeding an output FIFO toward execute.
// Optional perf counters are built when DECODE_STAGE_PERF_CNT_EN is defined.

package decode_stage_pkg;

   typedef logic [31:0] t_word;

   typedef enum logic [1:0] {
      OK_OP_IMM   = 2'd0,
      OK_OP_LUI   = 2'd1,
      OK_OP_AUIPC = 2'd2
   } t_op_kind;

   typedef enum logic [3:0] {
      FK_ADD  = 4'd0,
      FK_SLT  = 4'd1,
      FK_SLTU = 4'd2,
      FK_AND  = 4'd3,
      FK_OR   = 4'd4,
      FK_XOR  = 4'd5,
      FK_SLL  = 4'd6,
      FK_SRL  = 4'd7,
      FK_SRA  = 4'd8
   } t_func_kind;

   typedef struct packed {
      t_func_kind func;
      logic [4:0] dest;
      logic [4:0] src;
      t_word      imm;
   } t_op_imm_instr;

   typedef struct packed {
      logic [4:0] dest;
      t_word      imm;
   } t_op_lui_instr;

   typedef struct packed {
      logic [4:0] dest;
      t_word      imm;
   } t_op_auipc_instr;

   localparam int unsigned UnionW = $bits(t_op_imm_instr);

   // Narrower payloads sit right-aligned with zero padding above them.
   typedef struct packed {
      logic [UnionW-$bits(t_op_lui_instr)-1:0] pad;
      t_op_lui_instr                           instr;
   } t_op_lui_slot;

   typedef struct packed {
      logic [UnionW-$bits(t_op_auipc_instr)-1:0] pad;
      t_op_auipc_instr                           instr;
   } t_op_auipc_slot;

   typedef union packed {
      t_op_imm_instr  op_imm;
      t_op_lui_slot   op_lui;
      t_op_auipc_slot op_auipc;
   } t_instr_data_union;

   typedef struct packed {
      t_op_kind          kind;
      t_instr_data_union data;
   } t_decoded_instr;

endpackage

module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            fetch_valid,
   output logic            fetch_ready,
   input  t_word           fetch_instr,
   input  logic [XLEN-1:0] fetch_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output t_decoded_instr  dec_instr,
   output logic [XLEN-1:0] dec_pc,
   output logic            dec_illegal
`ifdef DECODE_STAGE_PERF_CNT_EN
   ,
   output logic [31:0]     perf_decoded,
   output logic [31:0]     perf_illegal
`endif
);

   localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [CntW-1:0] CntFull = CntW'(QUEUE_DEPTH);

   localparam logic [6:0] OpcOpImm = 7'h13;
   localparam logic [6:0] OpcLui   = 7'h37;
   localparam logic [6:0] OpcAuipc = 7'h17;

   if (XLEN != 32) begin : g_xlen_chk
      $error("decode_stage: XLEN must be 32");
   end
   if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("decode_stage: QUEUE_DEPTH must be a power of two >= 2");
   end

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push, pop;

   t_decoded_instr  mem_instr   [QUEUE_DEPTH];
   logic [XLEN-1:0] mem_pc      [QUEUE_DEPTH];
   logic            mem_illegal [QUEUE_DEPTH];

   t_op_imm_instr   imm_f;
   t_op_lui_instr   lui_f;
   t_op_auipc_instr auipc_f;
   t_decoded_instr  dec_d;
   logic            illegal_d;

   assign push = fetch_valid & fetch_ready;
   assign pop  = dec_valid & dec_ready;

   // Decoder: purely a function of the incoming word.
   always_comb begin
      imm_f     = '0;
      lui_f     = '0;
      auipc_f   = '0;
      dec_d     = '0;
      illegal_d = 1'b0;
      case (fetch_instr[6:0])
         OpcOpImm: begin
            imm_f.dest = fetch_instr[11:7];
            imm_f.src  = fetch_instr[19:15];
            imm_f.imm  = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
            unique case (fetch_instr[14:12])
               3'b000: imm_f.func = FK_ADD;
               3'b010: imm_f.func = FK_SLT;
               3'b011: imm_f.func = FK_SLTU;
               3'b100: imm_f.func = FK_XOR;
               3'b110: imm_f.func = FK_OR;
               3'b111: imm_f.func = FK_AND;
               3'b001: begin
                  imm_f.func = FK_SLL;
                  imm_f.imm  = {27'b0, fetch_instr[24:20]};
                  if (fetch_instr[31:25] != 7'h00) illegal_d = 1'b1;
               end
               default: begin
                  imm_f.imm = {27'b0, fetch_instr[24:20]};
                  if (fetch_instr[31:25] == 7'h00) begin
                     imm_f.func = FK_SRL;
                  end else if (fetch_instr[31:25] == 7'h20) begin
                     imm_f.func = FK_SRA;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
            endcase
            dec_d.kind        = OK_OP_IMM;
            dec_d.data.op_imm = imm_f;
         end
         OpcLui: begin
            lui_f.dest              = fetch_instr[11:7];
            lui_f.imm               = {fetch_instr[31:12], 12'b0};
            dec_d.kind              = OK_OP_LUI;
            dec_d.data.op_lui.instr = lui_f;
         end
         OpcAuipc: begin
            auipc_f.dest              = fetch_instr[11:7];
            auipc_f.imm               = {fetch_instr[31:12], 12'b0};
            dec_d.kind                = OK_OP_AUIPC;
            dec_d.data.op_auipc.instr = auipc_f;
         end
         default: illegal_d = 1'b1;
      endcase
      if (fetch_instr[1:0] != 2'b11) illegal_d = 1'b1;
      if (illegal_d) dec_d = '0;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrOne;
         if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
         case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: reads are masked whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr_q]   <= dec_d;
         mem_pc[wr_ptr_q]      <= fetch_pc;
         mem_illegal[wr_ptr_q] <= illegal_d;
      end
   end

   always_comb begin
      fetch_ready = rst_n && (count_q < CntFull);
      dec_valid   = rst_n && (count_q != '0);
      dec_instr   = '0;
      dec_pc      = '0;
      dec_illegal = 1'b0;
      if (dec_valid) begin
         dec_instr   = mem_instr[rd_ptr_q];
         dec_pc      = mem_pc[rd_ptr_q];
         dec_illegal = mem_illegal[rd_ptr_q];
      end
   end

`ifdef DECODE_STAGE_PERF_CNT_EN
   logic [31:0] perf_decoded_q, perf_illegal_q;

   // Counts every accepted handshake, including ones a same-cycle flush discards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_decoded_q <= '0;
         perf_illegal_q <= '0;
      end else begin
         if (push && (perf_decoded_q != 32'hFFFF_FFFF)) begin
            perf_decoded_q <= perf_decoded_q + 32'd1;
         end
         if (push && illegal_d && (perf_illegal_q != 32'hFFFF_FFFF)) begin
            perf_illegal_q <= perf_illegal_q + 32'd1;
         end
      end
   end

   assign perf_decoded = perf_decoded_q;
   assign perf_illegal = perf_illegal_q;
`endif

endmodule
